alu_rs: RTL and testbench

- Reservation station for the ALU, sitting on the receiving end of the ROB dispatch/broadcast interface.
- Accepts dispatched ALU instructions from the ROB and holds them until both operands are valid.
- Captures missing operands by snooping the ROB result broadcast (tag, data).
- Issues ready entries to the ALU, lowest index first, and backpressures the ROB through stall_alu.

---
 rtl/alu_rs.sv | 127 ++++++++++++
 tb/tb_alu_rs.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_rs.sv
// ALU reservation station: holds dispatched ops until both operands are captured
// (at dispatch, by dispatch forwarding or by broadcast snoop), then issues the lowest ready index.
module alu_rs #(
  parameter int unsigned width = 32,
  parameter int unsigned size  = 8,
  parameter int unsigned tag_w = 4,
  parameter int unsigned op_w  = 3
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       load_alu_rs,
  input  logic [op_w-1:0]            d_op,
  input  logic [tag_w-1:0]           d_tag,
  input  logic [width-1:0]           d_vj,
  input  logic [width-1:0]           d_vk,
  input  logic                       d_rj,
  input  logic                       d_rk,
  input  logic [tag_w-1:0]           d_qj,
  input  logic [tag_w-1:0]           d_qk,
  input  logic                       bcast_valid,
  input  logic [tag_w-1:0]           bcast_tag,
  input  logic [width-1:0]           bcast_data,
  output logic                       stall_alu,
  output logic                       issue_valid,
  output logic [op_w-1:0]            issue_op,
  output logic [width-1:0]           issue_a,
  output logic [width-1:0]           issue_b,
  output logic [tag_w-1:0]           issue_tag,
  input  logic                       issue_ready,
  output logic [$clog2(size+1)-1:0]  count
);
  localparam int unsigned cnt_w = $clog2(size + 1);
  localparam int unsigned idx_w = (size > 1) ? $clog2(size) : 1;

  logic [size-1:0]  ent_valid;
  logic [size-1:0]  ent_rj;
  logic [size-1:0]  ent_rk;
  logic [op_w-1:0]  ent_op  [size];
  logic [tag_w-1:0] ent_tag [size];
  logic [tag_w-1:0] ent_qj  [size];
  logic [tag_w-1:0] ent_qk  [size];
  logic [width-1:0] ent_vj  [size];
  logic [width-1:0] ent_vk  [size];

  logic [size-1:0]  ent_ready;
  logic [idx_w-1:0] sel_idx;
  logic [idx_w-1:0] free_idx;
  logic             disp_fire;
  logic             issue_fire;
  logic             fwd_j;
  logic             fwd_k;

  assign ent_ready  = ent_valid & ent_rj & ent_rk;
  assign stall_alu  = (count == cnt_w'(size));
  assign issue_valid = |ent_ready;
  assign disp_fire  = load_alu_rs && !stall_alu;
  assign issue_fire = issue_valid && issue_ready;
  assign fwd_j      = bcast_valid && !d_rj && (d_qj == bcast_tag);
  assign fwd_k      = bcast_valid && !d_rk && (d_qk == bcast_tag);

  // Descending scan so the lowest index wins both the issue select and the free search
  always_comb begin
    sel_idx  = '0;
    free_idx = '0;
    for (int i = int'(size) - 1; i >= 0; i--) begin
      if (ent_ready[i]) sel_idx = idx_w'(i);
      if (!ent_valid[i]) free_idx = idx_w'(i);
    end
  end

  assign issue_op  = issue_valid ? ent_op[sel_idx]  : '0;
  assign issue_a   = issue_valid ? ent_vj[sel_idx]  : '0;
  assign issue_b   = issue_valid ? ent_vk[sel_idx]  : '0;
  assign issue_tag = issue_valid ? ent_tag[sel_idx] : '0;

  // Entry storage, snoop, dispatch write, issue clear and occupancy count
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ent_valid <= '0;
      ent_rj    <= '0;
      ent_rk    <= '0;
      for (int i = 0; i < int'(size); i++) begin
        ent_op[i]  <= '0;
        ent_tag[i] <= '0;
        ent_qj[i]  <= '0;
        ent_qk[i]  <= '0;
        ent_vj[i]  <= '0;
        ent_vk[i]  <= '0;
      end
      count <= '0;
    end else if (flush) begin
      ent_valid <= '0;
      ent_rj    <= '0;
      ent_rk    <= '0;
      count     <= '0;
    end else begin
      if (bcast_valid) begin
        for (int i = 0; i < int'(size); i++) begin
          if (ent_valid[i] && !ent_rj[i] && (ent_qj[i] == bcast_tag)) begin
            ent_vj[i] <= bcast_data;
            ent_rj[i] <= 1'b1;
          end
          if (ent_valid[i] && !ent_rk[i] && (ent_qk[i] == bcast_tag)) begin
            ent_vk[i] <= bcast_data;
            ent_rk[i] <= 1'b1;
          end
        end
      end
      // The issued entry is ready, so the snoop above never touches it
      if (issue_fire) ent_valid[sel_idx] <= 1'b0;
      if (disp_fire) begin
        ent_valid[free_idx] <= 1'b1;
        ent_op[free_idx]    <= d_op;
        ent_tag[free_idx]   <= d_tag;
        ent_qj[free_idx]    <= d_qj;
        ent_qk[free_idx]    <= d_qk;
        ent_vj[free_idx]    <= fwd_j ? bcast_data : d_vj;
        ent_vk[free_idx]    <= fwd_k ? bcast_data : d_vk;
        ent_rj[free_idx]    <= d_rj | fwd_j;
        ent_rk[free_idx]    <= d_rk | fwd_k;
      end
      count <= count + cnt_w'(disp_fire) - cnt_w'(issue_fire);
    end
  end

endmodule

// File: tb/tb_alu_rs.sv
// Bench for alu_rs: directed scenarios plus randomized traffic, all checked against a
// slot-array reference model that applies the station rules once per clock edge.
module tb_alu_rs;
  localparam int N = 8;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        load_alu_rs;
  logic [2:0]  d_op;
  logic [3:0]  d_tag;
  logic [31:0] d_vj, d_vk;
  logic        d_rj, d_rk;
  logic [3:0]  d_qj, d_qk;
  logic        bcast_valid;
  logic [3:0]  bcast_tag;
  logic [31:0] bcast_data;
  logic        stall_alu;
  logic        issue_valid;
  logic [2:0]  issue_op;
  logic [31:0] issue_a, issue_b;
  logic [3:0]  issue_tag;
  logic        issue_ready;
  logic [3:0]  count;

  int n_cmp = 0;
  int n_bad = 0;

  alu_rs #(.width(32), .size(8), .tag_w(4), .op_w(3)) dut (
    .clk(clk), .rst(rst), .flush(flush), .load_alu_rs(load_alu_rs),
    .d_op(d_op), .d_tag(d_tag), .d_vj(d_vj), .d_vk(d_vk),
    .d_rj(d_rj), .d_rk(d_rk), .d_qj(d_qj), .d_qk(d_qk),
    .bcast_valid(bcast_valid), .bcast_tag(bcast_tag), .bcast_data(bcast_data),
    .stall_alu(stall_alu), .issue_valid(issue_valid), .issue_op(issue_op),
    .issue_a(issue_a), .issue_b(issue_b), .issue_tag(issue_tag),
    .issue_ready(issue_ready), .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: one record per slot
  bit          m_valid [N];
  bit          m_rj [N];
  bit          m_rk [N];
  logic [2:0]  m_op [N];
  logic [3:0]  m_tag [N];
  logic [3:0]  m_qj [N];
  logic [3:0]  m_qk [N];
  logic [31:0] m_vj [N];
  logic [31:0] m_vk [N];

  function automatic int m_occ();
    int n = 0;
    for (int i = 0; i < N; i++) if (m_valid[i]) n++;
    return n;
  endfunction

  function automatic int m_sel();
    for (int i = 0; i < N; i++) if (m_valid[i] && m_rj[i] && m_rk[i]) return i;
    return -1;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_valid[i] = 0; m_rj[i] = 0; m_rk[i] = 0;
    end
  endtask

  // Applies the effect of the coming clock edge using the currently driven inputs
  task automatic model_step();
    int sel, fr;
    bit accept;
    if (flush) begin
      model_reset();
      return;
    end
    sel = m_sel();
    accept = load_alu_rs && (m_occ() < N);
    fr = -1;
    for (int i = N - 1; i >= 0; i--) if (!m_valid[i]) fr = i;
    if (bcast_valid) begin
      for (int i = 0; i < N; i++) begin
        if (m_valid[i] && !m_rj[i] && m_qj[i] == bcast_tag) begin m_vj[i] = bcast_data; m_rj[i] = 1; end
        if (m_valid[i] && !m_rk[i] && m_qk[i] == bcast_tag) begin m_vk[i] = bcast_data; m_rk[i] = 1; end
      end
    end
    if (sel >= 0 && issue_ready) m_valid[sel] = 0;
    if (accept) begin
      m_valid[fr] = 1; m_op[fr] = d_op; m_tag[fr] = d_tag;
      m_qj[fr] = d_qj; m_qk[fr] = d_qk;
      m_rj[fr] = d_rj; m_vj[fr] = d_vj;
      m_rk[fr] = d_rk; m_vk[fr] = d_vk;
      if (bcast_valid && !d_rj && d_qj == bcast_tag) begin m_rj[fr] = 1; m_vj[fr] = bcast_data; end
      if (bcast_valid && !d_rk && d_qk == bcast_tag) begin m_rk[fr] = 1; m_vk[fr] = bcast_data; end
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    load_alu_rs = 0;
    bcast_valid = 0;
    flush = 0;
  endtask

  task automatic disp(input logic [2:0] op, input logic [3:0] tag,
                      input logic [31:0] vj, input logic rj, input logic [3:0] qj,
                      input logic [31:0] vk, input logic rk, input logic [3:0] qk);
    load_alu_rs = 1; d_op = op; d_tag = tag;
    d_vj = vj; d_rj = rj; d_qj = qj;
    d_vk = vk; d_rk = rk; d_qk = qk;
  endtask

  task automatic bcast(input logic [3:0] t, input logic [31:0] d);
    bcast_valid = 1; bcast_tag = t; bcast_data = d;
  endtask

  task automatic test_reset();
    @(posedge clk); #1;
    n_cmp++; if (count !== 4'd0) begin n_bad++; $display("FAIL reset_count: got %0d want 0", count); end
    n_cmp++; if (stall_alu !== 1'b0) begin n_bad++; $display("FAIL reset_stall: got %b want 0", stall_alu); end
    n_cmp++; if (issue_valid !== 1'b0) begin n_bad++; $display("FAIL reset_issue_valid: got %b want 0", issue_valid); end
    n_cmp++; if ({issue_a, issue_b, issue_tag, issue_op} !== 71'd0) begin n_bad++; $display("FAIL reset_issue_data: got %h want 0", {issue_a, issue_b, issue_tag, issue_op}); end
    rst = 1;
    issue_ready = 0;
    disp(3'd1, 4'd1, 32'd0, 0, 4'd9, 32'd3, 1, 4'd0);  tick();
    disp(3'd1, 4'd2, 32'd0, 0, 4'd10, 32'd3, 1, 4'd0); tick();
    disp(3'd1, 4'd3, 32'd8, 1, 4'd0, 32'd3, 1, 4'd0);  tick();
    n_cmp++; if (count !== 4'd3 || issue_valid !== 1'b1) begin n_bad++; $display("FAIL prefill: got count=%0d iv=%b want count=3 iv=1", count, issue_valid); end
    #2 rst = 0;
    #1;
    model_reset();
    n_cmp++; if (count !== 4'd0) begin n_bad++; $display("FAIL async_reset_count: got %0d want 0", count); end
    n_cmp++; if (issue_valid !== 1'b0 || stall_alu !== 1'b0) begin n_bad++; $display("FAIL async_reset_flags: got iv=%b stall=%b want 0 0", issue_valid, stall_alu); end
    @(posedge clk); #1;
    rst = 1;
    disp(3'd2, 4'd4, 32'd1, 1, 4'd0, 32'd1, 1, 4'd0); tick();
    disp(3'd2, 4'd5, 32'd2, 1, 4'd0, 32'd2, 1, 4'd0); tick();
    n_cmp++; if (issue_tag !== 4'd4 || count !== 4'd2) begin n_bad++; $display("FAIL post_reset_entry0: got tag=%0d count=%0d want tag=4 count=2", issue_tag, count); end
    flush = 1; tick();
  endtask

  task automatic test_ready_dispatch();
    issue_ready = 1;
    disp(3'd0, 4'd2, 32'd5, 1, 4'd0, 32'd7, 1, 4'd0); tick();
    n_cmp++; if (issue_valid !== 1'b1 || issue_a !== 32'd5 || issue_b !== 32'd7 || issue_tag !== 4'd2 || issue_op !== 3'd0)
      begin n_bad++; $display("FAIL direct_issue: got iv=%b a=%0h b=%0h tag=%0d op=%0d want 1 5 7 2 0", issue_valid, issue_a, issue_b, issue_tag, issue_op); end
    tick();
    n_cmp++; if (count !== 4'd0 || issue_valid !== 1'b0) begin n_bad++; $display("FAIL direct_drain: got count=%0d iv=%b want 0 0", count, issue_valid); end
  endtask

  task automatic test_snoop();
    issue_ready = 1;
    disp(3'd3, 4'd3, 32'hDEAD, 0, 4'd6, 32'd1, 1, 4'd0); tick();
    n_cmp++; if (issue_valid !== 1'b0 || count !== 4'd1) begin n_bad++; $display("FAIL snoop_wait1: got iv=%b count=%0d want 0 1", issue_valid, count); end
    tick();
    bcast(4'd6, 32'h10);
    n_cmp++; if (issue_valid !== 1'b0) begin n_bad++; $display("FAIL snoop_bcast_cycle: got iv=%b want 0", issue_valid); end
    tick();
    n_cmp++; if (issue_valid !== 1'b1 || issue_a !== 32'h10 || issue_b !== 32'd1 || issue_tag !== 4'd3)
      begin n_bad++; $display("FAIL snoop_issue: got iv=%b a=%0h b=%0h tag=%0d want 1 10 1 3", issue_valid, issue_a, issue_b, issue_tag); end
    tick();
    n_cmp++; if (count !== 4'd0) begin n_bad++; $display("FAIL snoop_drain: got %0d want 0", count); end
  endtask

  task automatic test_forward();
    issue_ready = 1;
    disp(3'd4, 4'd5, 32'h0, 0, 4'd4, 32'd2, 1, 4'd0);
    bcast(4'd4, 32'hAB);
    tick();
    n_cmp++; if (issue_valid !== 1'b1 || issue_a !== 32'hAB || issue_b !== 32'd2)
      begin n_bad++; $display("FAIL forward: got iv=%b a=%0h b=%0h want 1 ab 2", issue_valid, issue_a, issue_b); end
    tick();
  endtask

  task automatic test_full();
    issue_ready = 0;
    for (int i = 0; i < N; i++) begin
      disp(3'd1, 4'(i), 32'd0, 0, 4'(8 + i), 32'd9, 1, 4'd0); tick();
    end
    n_cmp++; if (count !== 4'd8 || stall_alu !== 1'b1) begin n_bad++; $display("FAIL full: got count=%0d stall=%b want 8 1", count, stall_alu); end
    disp(3'd1, 4'd9, 32'd1, 1, 4'd0, 32'd1, 1, 4'd0); tick();
    n_cmp++; if (count !== 4'd8 || issue_valid !== 1'b0) begin n_bad++; $display("FAIL dropped_dispatch: got count=%0d iv=%b want 8 0", count, issue_valid); end
    issue_ready = 1;
    bcast(4'd13, 32'hCAFE); tick();
    n_cmp++; if (issue_valid !== 1'b1 || issue_tag !== 4'd5 || issue_a !== 32'hCAFE || stall_alu !== 1'b1)
      begin n_bad++; $display("FAIL entry5_issue: got iv=%b tag=%0d a=%0h stall=%b want 1 5 cafe 1", issue_valid, issue_tag, issue_a, stall_alu); end
    tick();
    n_cmp++; if (stall_alu !== 1'b0 || count !== 4'd7) begin n_bad++; $display("FAIL unstall: got stall=%b count=%0d want 0 7", stall_alu, count); end
    issue_ready = 0;
    disp(3'd6, 4'd14, 32'h55, 1, 4'd0, 32'h66, 1, 4'd0); tick();
    n_cmp++; if (count !== 4'd8 || issue_tag !== 4'd14 || issue_a !== 32'h55 || stall_alu !== 1'b1)
      begin n_bad++; $display("FAIL refill_slot5: got count=%0d tag=%0d a=%0h stall=%b want 8 14 55 1", count, issue_tag, issue_a, stall_alu); end
    flush = 1; tick();
  endtask

  task automatic test_hold_flush();
    issue_ready = 0;
    disp(3'd0, 4'd6, 32'd0, 0, 4'd1, 32'd0, 1, 4'd0);    tick();
    disp(3'd5, 4'd7, 32'h11, 1, 4'd0, 32'h22, 1, 4'd0);  tick();
    disp(3'd0, 4'd8, 32'd0, 0, 4'd2, 32'd0, 1, 4'd0);    tick();
    disp(3'd0, 4'd10, 32'd0, 0, 4'd3, 32'd0, 1, 4'd0);   tick();
    disp(3'd2, 4'd9, 32'h33, 1, 4'd0, 32'h44, 1, 4'd0);  tick();
    for (int c = 0; c < 3; c++) begin
      n_cmp++; if (issue_valid !== 1'b1 || issue_tag !== 4'd7 || issue_a !== 32'h11 || issue_b !== 32'h22 || issue_op !== 3'd5)
        begin n_bad++; $display("FAIL hold_c%0d: got iv=%b tag=%0d a=%0h b=%0h op=%0d want 1 7 11 22 5", c, issue_valid, issue_tag, issue_a, issue_b, issue_op); end
      tick();
    end
    issue_ready = 1;
    flush = 1; tick();
    n_cmp++; if (count !== 4'd0 || issue_valid !== 1'b0) begin n_bad++; $display("FAIL flush: got count=%0d iv=%b want 0 0", count, issue_valid); end
    bcast(4'd1, 32'h77); tick();
    n_cmp++; if (count !== 4'd0 || issue_valid !== 1'b0) begin n_bad++; $display("FAIL flush_no_survivor: got count=%0d iv=%b want 0 0", count, issue_valid); end
  endtask

  task automatic test_back_to_back();
    issue_ready = 1;
    disp(3'd1, 4'd1, 32'd1, 1, 4'd0, 32'd1, 1, 4'd0); tick();
    disp(3'd1, 4'd2, 32'd2, 1, 4'd0, 32'd2, 1, 4'd0); tick();
    n_cmp++; if (count !== 4'd1 || issue_tag !== 4'd2) begin n_bad++; $display("FAIL b2b: got count=%0d tag=%0d want 1 2", count, issue_tag); end
    tick();
    n_cmp++; if (count !== 4'd0) begin n_bad++; $display("FAIL b2b_drain: got %0d want 0", count); end
  endtask

  task automatic test_random();
    int e, occ;
    for (int c = 0; c < 400; c++) begin
      e = m_sel();
      occ = m_occ();
      n_cmp++; if (count !== 4'(occ)) begin n_bad++; $display("FAIL rnd_count c%0d: got %0d want %0d", c, count, occ); end
      n_cmp++; if (stall_alu !== 1'(occ == N)) begin n_bad++; $display("FAIL rnd_stall c%0d: got %b want %b", c, stall_alu, occ == N); end
      n_cmp++; if (issue_valid !== 1'(e >= 0)) begin n_bad++; $display("FAIL rnd_iv c%0d: got %b want %b", c, issue_valid, e >= 0); end
      if (e >= 0) begin
        n_cmp++;
        if ({issue_op, issue_tag, issue_a, issue_b} !== {m_op[e], m_tag[e], m_vj[e], m_vk[e]})
          begin n_bad++; $display("FAIL rnd_issue c%0d: got %h want %h", c, {issue_op, issue_tag, issue_a, issue_b}, {m_op[e], m_tag[e], m_vj[e], m_vk[e]}); end
      end
      if ($urandom_range(0, 1) == 0)
        disp(3'($urandom), 4'($urandom), $urandom, 1'($urandom), 4'($urandom_range(0, 3)),
             $urandom, 1'($urandom), 4'($urandom_range(0, 3)));
      if ($urandom_range(0, 2) != 0) bcast(4'($urandom_range(0, 4)), $urandom);
      issue_ready = 1'($urandom_range(0, 3) != 0);
      flush = 1'($urandom_range(0, 39) == 0);
      tick();
    end
  endtask

  initial begin
    rst = 0; flush = 0; load_alu_rs = 0; issue_ready = 0;
    d_op = '0; d_tag = '0; d_vj = '0; d_vk = '0; d_rj = 0; d_rk = 0; d_qj = '0; d_qk = '0;
    bcast_valid = 0; bcast_tag = '0; bcast_data = '0;
    model_reset();
    test_reset();
    test_ready_dispatch();
    test_snoop();
    test_forward();
    test_full();
    test_hold_flush();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
